// File: rtl/step_pkg.sv
// Shared types and widths for the step tracker slice.
// Holds the FSM state enum, output widths and the default clock rate.
package step_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam int STEP_W = 14;
   localparam int RATE_W = 8;
   localparam int DIST_W = 4;
   localparam int CLK_HZ_DEFAULT = 100_000_000;

   // Add one step to a window accumulator, sticking at all-ones.
   function automatic logic [RATE_W-1:0] sat_inc(
      input logic [RATE_W-1:0] v,
      input logic              inc
   );
      return (inc && (v != '1)) ? v + RATE_W'(1) : v;
   endfunction

endpackage

// File: rtl/step_tracker_if.sv
// Step-pulse link from the pulse generator to the tracker.
// master: pulse generator (drives pulse, pulsestart); slave: tracker.
interface step_tracker_if;

   logic pulse;
   logic pulsestart;

   modport master (
      output pulse,
      output pulsestart
   );

   modport slave (
      input pulse,
      input pulsestart
   );

endinterface

// File: rtl/step_tracker_sec_timer.sv
// One-second window timer: counts 0..CLK_HZ-1 while enabled.
// Ports: clk, reset (async high), en, clr (sync), tick (end-of-window strobe).
module sec_timer
   import step_pkg::*;
#(
   parameter int CLK_HZ = CLK_HZ_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

   logic [CW-1:0] cnt;

   // Strobe is high during the last cycle of the window so the
   // owner can close the window on the same edge the count wraps.
   assign tick = en & ~clr & (cnt == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/step_tracker.sv
// Step tracker: counts steps, distance, steps/second and active seconds.
// Ports: clk, reset (async high), pg (step_tracker_if.slave), clr (sync),
//   step_count, distance, rate, active_secs, sec_tick, overflow.
// Build option: define STEP_SATURATE_EN to saturate step_count at
//   STEP_MAX with a sticky overflow flag; otherwise step_count wraps.
module step_tracker
   import step_pkg::*;
#(
   parameter int CLK_HZ              = CLK_HZ_DEFAULT,
   parameter int STEP_MAX            = 9999,
   parameter int STEPS_PER_HALF_MILE = 1024,
   parameter int ACTIVE_RATE         = 32
) (
   input  logic              clk,
   input  logic              reset,
   step_tracker_if.slave     pg,
   input  logic              clr,
   output logic [STEP_W-1:0] step_count,
   output logic [DIST_W-1:0] distance,
   output logic [RATE_W-1:0] rate,
   output logic [RATE_W-1:0] active_secs,
   output logic              sec_tick,
   output logic              overflow
);

   localparam int SHIFT = $clog2(STEPS_PER_HALF_MILE);
   localparam logic [STEP_W-1:0] SMAX = STEP_W'(STEP_MAX);
   localparam logic [RATE_W-1:0] ACT_TH = RATE_W'(ACTIVE_RATE);

   state_t            state;
   logic              pulse_q;
   logic              run;
   logic              step;
   logic              tmr_clr;
   logic [RATE_W-1:0] rate_acc;
   logic [RATE_W-1:0] rate_sum;

   assign run      = (state == RUN);
   assign step     = run & pg.pulse & ~pulse_q;
   assign tmr_clr  = clr | (state == IDLE);
   // Window total including a step landing on the tick cycle.
   assign rate_sum = sat_inc(rate_acc, step);
   assign distance = DIST_W'(step_count >> SHIFT);

   sec_timer #(
      .CLK_HZ (CLK_HZ)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .en    (run),
      .clr   (tmr_clr),
      .tick  (sec_tick)
   );

`ifndef STEP_SATURATE_EN
   assign overflow = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         pulse_q     <= 1'b0;
         step_count  <= '0;
         rate        <= '0;
         rate_acc    <= '0;
         active_secs <= '0;
`ifdef STEP_SATURATE_EN
         overflow    <= 1'b0;
`endif
      end else if (clr) begin
         state       <= IDLE;
         pulse_q     <= 1'b0;
         step_count  <= '0;
         rate        <= '0;
         rate_acc    <= '0;
         active_secs <= '0;
`ifdef STEP_SATURATE_EN
         overflow    <= 1'b0;
`endif
      end else begin
         pulse_q <= pg.pulse;

         unique case (state)
            IDLE:    if (pg.pulsestart) state <= RUN;
            RUN:     if (!pg.pulsestart) state <= PAUSE;
            PAUSE:   if (pg.pulsestart) state <= RUN;
            default: state <= IDLE;
         endcase

         if (step) begin
`ifdef STEP_SATURATE_EN
            if (step_count == SMAX) overflow <= 1'b1;
            else step_count <= step_count + STEP_W'(1);
`else
            step_count <= (step_count == SMAX) ?
               '0 : step_count + STEP_W'(1);
`endif
         end

         if (sec_tick) begin
            rate     <= rate_sum;
            rate_acc <= '0;
            if ((rate_sum >= ACT_TH) && (active_secs != '1))
               active_secs <= active_secs + RATE_W'(1);
         end else if (run) begin
            rate_acc <= rate_sum;
         end
      end
   end

endmodule

// File: tb/tb_step_tracker.sv
// Self-checking bench for step_tracker: two instances (large and small
// STEP_MAX) driven in lock-step and compared against a behavioural model.
module tb_step_tracker;

   localparam int CLK = 100;

   logic clk = 1'b0;
   logic reset;
   logic clr;

   step_tracker_if pif ();

   logic [13:0] sc_a, sc_b;
   logic [3:0]  dist_a, dist_b;
   logic [7:0]  rate_a, rate_b, act_a, act_b;
   logic        tick_a, tick_b, ovf_a, ovf_b;

   int checks = 0;
   int errors = 0;

   step_tracker #(
      .CLK_HZ(CLK), .STEP_MAX(9999),
      .STEPS_PER_HALF_MILE(1024), .ACTIVE_RATE(32)
   ) dut_a (
      .clk(clk), .reset(reset), .pg(pif), .clr(clr),
      .step_count(sc_a), .distance(dist_a), .rate(rate_a),
      .active_secs(act_a), .sec_tick(tick_a), .overflow(ovf_a)
   );

   step_tracker #(
      .CLK_HZ(CLK), .STEP_MAX(15),
      .STEPS_PER_HALF_MILE(4), .ACTIVE_RATE(3)
   ) dut_b (
      .clk(clk), .reset(reset), .pg(pif), .clr(clr),
      .step_count(sc_b), .distance(dist_b), .rate(rate_b),
      .active_secs(act_b), .sec_tick(tick_b), .overflow(ovf_b)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int m_sc[2], m_acc[2], m_rate[2], m_act[2], m_cyc[2];
   bit m_run[2], m_pq[2], m_ovf[2];

   function automatic int pmax(input int k);
      return (k == 0) ? 9999 : 15;
   endfunction

   function automatic int pshm(input int k);
      return (k == 0) ? 1024 : 4;
   endfunction

   function automatic int pact(input int k);
      return (k == 0) ? 32 : 3;
   endfunction

   task automatic mdl_zero();
      for (int k = 0; k < 2; k++) begin
         m_sc[k] = 0; m_acc[k] = 0; m_rate[k] = 0;
         m_act[k] = 0; m_cyc[k] = 0;
         m_run[k] = 0; m_pq[k] = 0; m_ovf[k] = 0;
      end
   endtask

   // Counting happens in cycles that follow a cycle with pulsestart
   // high; a window closes after CLK such counting cycles.
   task automatic mdl_edge(input bit p, input bit ps, input bit c);
      bit st;
      int a;
      if (c) begin
         mdl_zero();
         return;
      end
      for (int k = 0; k < 2; k++) begin
         st = m_run[k] && p && !m_pq[k];
         if (m_run[k]) begin
            if (st) begin
`ifdef STEP_SATURATE_EN
               if (m_sc[k] == pmax(k)) m_ovf[k] = 1;
               else m_sc[k] = m_sc[k] + 1;
`else
               m_sc[k] = (m_sc[k] + 1) % (pmax(k) + 1);
`endif
            end
            a = m_acc[k] + (st ? 1 : 0);
            if (a > 255) a = 255;
            m_cyc[k] = m_cyc[k] + 1;
            if (m_cyc[k] == CLK) begin
               m_cyc[k] = 0;
               m_rate[k] = a;
               if (a >= pact(k) && m_act[k] < 255) m_act[k] = m_act[k] + 1;
               m_acc[k] = 0;
            end else begin
               m_acc[k] = a;
            end
         end
         m_run[k] = ps;
         m_pq[k] = p;
      end
   endtask

   function automatic logic [35:0] obs(input int k);
      if (k == 0) return {sc_a, dist_a, rate_a, act_a, tick_a, ovf_a};
      return {sc_b, dist_b, rate_b, act_b, tick_b, ovf_b};
   endfunction

   function automatic logic [35:0] expv(input int k);
      logic t;
      t = m_run[k] && (m_cyc[k] == CLK - 1);
      return {14'(m_sc[k]), 4'(m_sc[k] / pshm(k)), 8'(m_rate[k]),
              8'(m_act[k]), t, m_ovf[k]};
   endfunction

   // One clock: drive at negedge, model the edge, return at next negedge.
   task automatic cyc(input bit p, input bit ps, input bit c);
      pif.pulse = p;
      pif.pulsestart = ps;
      clr = c;
      @(posedge clk);
      mdl_edge(p, ps, c);
      @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      clr = 1'b0;
      pif.pulse = 1'b0;
      pif.pulsestart = 1'b0;
      mdl_zero();
      repeat (2) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (obs(k) !== 36'h0) begin
            errors++;
            $display("FAIL reset_state dut%0d got %h exp %h", k, obs(k), 36'h0);
         end
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_window_rate();
      cyc(0, 0, 1);
      cyc(0, 1, 0);
      for (int i = 1; i <= 300; i++) begin
         cyc((i % 4) >= 2, 1, 0);
         if (i % 100 == 0) begin
            checks++;
            if (rate_a !== 8'd25) begin
               errors++;
               $display("FAIL rate_25 win %0d got %0d exp 25", i / 100, rate_a);
            end
         end
      end
      checks++;
      if (sc_a !== 14'd75 || act_a !== 8'd0) begin
         errors++;
         $display("FAIL steps_75 got sc=%0d act=%0d exp sc=75 act=0", sc_a, act_a);
      end
      for (int j = 0; j < 200; j++) begin
         cyc((j % 2) >= 1, 1, 0);
         if (j % 100 == 99) begin
            checks++;
            if (rate_a !== 8'd50) begin
               errors++;
               $display("FAIL rate_50 j %0d got %0d exp 50", j, rate_a);
            end
         end
      end
      checks++;
      if (sc_a !== 14'd175 || act_a !== 8'd2 || dist_a !== 4'd0) begin
         errors++;
         $display("FAIL steps_175 got sc=%0d act=%0d dist=%0d exp 175/2/0",
                  sc_a, act_a, dist_a);
      end
      checks++;
      if (obs(1) !== expv(1)) begin
         errors++;
         $display("FAIL window_small got %h exp %h", obs(1), expv(1));
      end
   endtask

   task automatic test_held_high();
      bit seen;
      seen = 0;
      cyc(0, 1, 0);
      for (int i = 0; i < 500; i++) begin
         cyc(1, 1, 0);
         if (!seen && m_cyc[0] == 0) begin
            seen = 1;
            checks++;
            if (rate_a !== 8'd1) begin
               errors++;
               $display("FAIL held_rate got %0d exp 1", rate_a);
            end
         end
      end
      checks++;
      if (sc_a !== 14'd176 || rate_a !== 8'd0) begin
         errors++;
         $display("FAIL held_once got sc=%0d rate=%0d exp 176/0", sc_a, rate_a);
      end
   endtask

   task automatic test_wrap();
      cyc(0, 0, 1);
      cyc(0, 1, 0);
      for (int j = 0; j < 34; j++) cyc((j % 2) >= 1, 1, 0);
      checks++;
`ifdef STEP_SATURATE_EN
      if (sc_b !== 14'd15 || ovf_b !== 1'b1) begin
         errors++;
         $display("FAIL sat_17 got sc=%0d ovf=%0d exp 15/1", sc_b, ovf_b);
      end
`else
      if (sc_b !== 14'd1 || ovf_b !== 1'b0) begin
         errors++;
         $display("FAIL wrap_17 got sc=%0d ovf=%0d exp 1/0", sc_b, ovf_b);
      end
`endif
      checks++;
      if (sc_a !== 14'd17 || ovf_a !== 1'b0) begin
         errors++;
         $display("FAIL big_17 got sc=%0d ovf=%0d exp 17/0", sc_a, ovf_a);
      end
   endtask

   task automatic test_pause();
      logic [13:0] sc0;
      int ticks, first;
      ticks = 0;
      first = -1;
      cyc(0, 0, 0);
      sc0 = sc_a;
      for (int i = 0; i < 299; i++) begin
         cyc(i % 2 == 0, 0, 0);
         if (tick_a) ticks++;
      end
      checks++;
      if (sc_a !== sc0 || ticks != 0) begin
         errors++;
         $display("FAIL pause_hold got sc=%0d ticks=%0d exp sc=%0d ticks=0",
                  sc_a, ticks, sc0);
      end
      for (int k = 0; k < 200 && first < 0; k++) begin
         cyc(k % 2 == 1, 1, 0);
         if (tick_a) first = k;
      end
      checks++;
      if (first != CLK - 1 - 35) begin
         errors++;
         $display("FAIL resume_tick got %0d exp %0d", first, CLK - 1 - 35);
      end
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (obs(k) !== expv(k)) begin
            errors++;
            $display("FAIL resume_state dut%0d got %h exp %h", k, obs(k), expv(k));
         end
      end
   endtask

   task automatic test_distance_reset();
      cyc(0, 0, 1);
      cyc(0, 1, 0);
      for (int j = 0; j < 4096; j++) cyc((j % 2) >= 1, 1, 0);
      checks++;
      if (sc_a !== 14'd2048 || dist_a !== 4'd2) begin
         errors++;
         $display("FAIL dist_2 got sc=%0d dist=%0d exp 2048/2", sc_a, dist_a);
      end
      for (int j = 0; j < 30; j++) cyc((j % 2) >= 1, 1, 0);
      #2 reset = 1'b1;
      #1;
      mdl_zero();
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (obs(k) !== 36'h0) begin
            errors++;
            $display("FAIL async_reset dut%0d got %h exp %h", k, obs(k), 36'h0);
         end
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_active_sat();
      cyc(0, 1, 0);
      for (int j = 0; j < 26000; j++) cyc((j % 2) >= 1, 1, 0);
      checks++;
      if (act_a !== 8'd255 || act_b !== 8'd255) begin
         errors++;
         $display("FAIL active_sat got a=%0d b=%0d exp 255/255", act_a, act_b);
      end
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (obs(k) !== expv(k)) begin
            errors++;
            $display("FAIL long_run dut%0d got %h exp %h", k, obs(k), expv(k));
         end
      end
   endtask

   task automatic test_random();
      bit p, ps, c;
      for (int i = 0; i < 3000; i++) begin
         p = ($urandom_range(0, 2) != 0);
         ps = ($urandom_range(0, 15) != 0);
         c = ($urandom_range(0, 599) == 0);
         cyc(p, ps, c);
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== expv(k)) begin
               errors++;
               $display("FAIL random dut%0d cyc %0d got %h exp %h",
                        k, i, obs(k), expv(k));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_window_rate();
      test_held_high();
      test_wrap();
      test_pause();
      test_distance_reset();
      test_active_sat();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
